mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline, directly downstream of ALU_stage.
- Consumes the ALU result as the effective address, or as the pass-through value for non-memory ops.
- Runs loads/stores against a data memory port with a req/gnt/rvalid handshake.
- Aligns and extends load data, and presents a registered writeback bundle to WB. Stalls EX while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles in WAIT before a bus fault is raised (range 1..255).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- inValid  input  1  EX presents a valid instruction
- result  input  32  ALU result / effective address
- storeData  input  32  rs2 value for stores
- funct3  input  3  funct3 from EX
- opcode  input  7  opcode from EX
- regdest  input  5  destination register
- stall  output  1  EX must hold its inputs
- memReq  output  1  memory request
- memWe  output  1  1 = write
- memAddr  output  32  word-aligned address
- memWdata  output  32  lane-shifted store data
- memBe  output  4  byte enables
- memGnt  input  1  request accepted
- memRvalid  input  1  read data valid
- memRdata  input  32  read data
- outValid  output  1  writeback bundle valid (1-cycle pulse)
- wbData  output  32  value to write back
- wbRegdest  output  5  writeback register
- wbWe  output  1  register-file write enable
- misaligned  output  1  alignment / illegal-funct3 fault (qualified by outValid)
- busFault  output  1  memory timeout fault (qualified by outValid)

Behaviour:
- FSM states: IDLE, REQ, WAIT.
- stall = (state != IDLE). stall is combinational from state only.
- Reset (async, any state): state=IDLE, timeout counter=0. All outputs 0, including memReq, which drops immediately. An in-flight transaction is abandoned; a later memRvalid is ignored.
- Accept rule: an instruction is accepted only in IDLE with inValid=1.
- Non-memory op (opcode not 0000011/0100011), accepted in IDLE:
  - Next cycle: outValid=1, wbData=result, wbRegdest=regdest.
  - wbWe=1 iff regdest!=0 and opcode is one of 0110011, 0010011, 0110111, 0010111, 1101111, 1100111.
  - Latency 1 cycle, no stall.
- Load (0000011), legal funct3 000/001/010/100/101 → LB/LH/LW/LBU/LHU. Store (0100011), legal funct3 000/001/010 → SB/SH/SW.
- Alignment check on accept:
  - Halfword: result[0]=0.
  - Word: result[1:0]=00.
  - Failure, or illegal funct3: no memory request. Next cycle outValid=1, misaligned=1, wbWe=0. Stay in IDLE.
- Legal memory op: capture address, data, funct3, regdest; go to REQ.
- REQ:
  - memReq=1 and all mem* outputs held stable until memGnt.
  - memAddr={addr[31:2],2'b00}.
  - Byte: memBe=0001<<addr[1:0], memWdata=storeData[7:0] replicated to 4 lanes.
  - Halfword: memBe=0011<<addr[1:0], memWdata=storeData[15:0] replicated.
  - Word: memBe=1111, memWdata=storeData.
  - memWe=1 for stores only.
- On memGnt in REQ:
  - Store: next cycle outValid=1, wbWe=0, state → IDLE.
  - Load: state → WAIT, counter cleared.
  - memReq deasserts the cycle after gnt.
- WAIT:
  - Counter increments each cycle.
  - On memRvalid: select lane by addr[1:0]; sign-extend (LB/LH) or zero-extend (LBU/LHU). Next cycle outValid=1, wbData=extended value, wbWe=(regdest!=0), state → IDLE.
  - If memRvalid coincides with counter reaching TIMEOUT_CYCLES, the data wins.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES: outValid=1, busFault=1, wbWe=0, state → IDLE.
- memRvalid outside WAIT is ignored.
- memGnt=0 forever in REQ stalls indefinitely; there is no timeout in REQ.
- The wb* fields hold their last value when outValid=0. misaligned and busFault are 0 whenever outValid=0.
- Back-to-back: a new op may be accepted in the same cycle the previous one's outValid pulses, since state is IDLE then.

Test Plan:
- Reset with rst_n=0 mid-REQ → memReq=0 and stall=0 immediately, all outputs 0; a memRvalid after release produces no outValid.
- ADD passthrough: result=0x00000009, regdest=5, opcode=0110011 → next cycle outValid=1, wbData=9, wbWe=1, stall never high. With regdest=0 → wbWe=0.
- SB: result=0x00001003, storeData=0x000000AB, gnt after 2 cycles → memAddr=0x00001000, memBe=1000, memWdata=0xABABABAB held 3 cycles. Then outValid=1, wbWe=0.
- LB/LBU: addr=0x00002002, memRdata=0x0080FF11, rvalid 3 cycles after gnt.
  - LB → wbData=0xFFFFFF80.
  - LBU → wbData=0x00000080.
  - stall high from accept until the outValid cycle.
- LW misaligned at 0x00000006 → no memReq, outValid=1, misaligned=1, wbWe=0. SH at 0x00000005 gives the same result.
- LW with no rvalid and TIMEOUT_CYCLES=4 → busFault=1 with outValid 4 cycles after gnt, wbWe=0, state back to IDLE. Rvalid on exactly the 4th cycle → data written, busFault=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores on a req/gnt/rvalid data port, aligns and
// extends load data, and presents a registered one-cycle writeback bundle.
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inValid,
   input  logic [31:0] result,
   input  logic [31:0] storeData,
   input  logic [2:0]  funct3,
   input  logic [6:0]  opcode,
   input  logic [4:0]  regdest,
   output logic        stall,
   output logic        memReq,
   output logic        memWe,
   output logic [31:0] memAddr,
   output logic [31:0] memWdata,
   output logic [3:0]  memBe,
   input  logic        memGnt,
   input  logic        memRvalid,
   input  logic [31:0] memRdata,
   output logic        outValid,
   output logic [31:0] wbData,
   output logic [4:0]  wbRegdest,
   output logic        wbWe,
   output logic        misaligned,
   output logic        busFault
);

   // Handshakes: memReq stays high with all mem* fields frozen until memGnt is
   // sampled high; memRvalid counts only in WAIT; outValid is a one-cycle pulse
   // with no backpressure; stall asks EX to hold whenever the FSM is not IDLE.

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [8:0] TMO      = 9'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t      state, state_nx;
   logic [31:0] addr_q, sdata_q;
   logic [2:0]  f3_q;
   logic [4:0]  rd_q;
   logic        store_q;
   logic [7:0]  cnt_q;

   logic        is_load, is_store, is_mem, f3_legal, aligned, accept, go_mem;
   logic        alu_we, timeout_hit;
   logic [8:0]  cnt_inc;
   logic [31:0] lane, load_ext;

   always_comb begin
      is_load  = (opcode == OP_LOAD);
      is_store = (opcode == OP_STORE);
      is_mem   = is_load | is_store;
      f3_legal = 1'b0;
      if (is_load)
         f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
      else if (is_store)
         f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      case (funct3[1:0])
         2'b01:   aligned = ~result[0];
         2'b10:   aligned = (result[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      accept = (state == IDLE) && inValid;
      go_mem = accept && is_mem && f3_legal && aligned;
      alu_we = (regdest != 5'd0) &&
               ((opcode == 7'b0110011) || (opcode == 7'b0010011) || (opcode == 7'b0110111) ||
                (opcode == 7'b0010111) || (opcode == 7'b1101111) || (opcode == 7'b1100111));
      cnt_inc     = {1'b0, cnt_q} + 9'd1;
      timeout_hit = (cnt_inc == TMO);
   end

   // Load lane select and extension from the captured offset and funct3
   always_comb begin
      lane = memRdata >> {addr_q[1:0], 3'b000};
      case (f3_q)
         3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_ext = {24'd0, lane[7:0]};
         3'b101:  load_ext = {16'd0, lane[15:0]};
         default: load_ext = memRdata;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (go_mem) state_nx = REQ;
         REQ:     if (memGnt) state_nx = store_q ? IDLE : WAIT;
         WAIT:    if (memRvalid || timeout_hit) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      stall    = (state != IDLE);
      memReq   = (state == REQ);
      memWe    = 1'b0;
      memAddr  = 32'd0;
      memBe    = 4'd0;
      memWdata = 32'd0;
      if (state == REQ) begin
         memWe   = store_q;
         memAddr = {addr_q[31:2], 2'b00};
         case (f3_q[1:0])
            2'b00: begin
               memBe    = 4'b0001 << addr_q[1:0];
               memWdata = {4{sdata_q[7:0]}};
            end
            2'b01: begin
               memBe    = 4'b0011 << addr_q[1:0];
               memWdata = {2{sdata_q[15:0]}};
            end
            default: begin
               memBe    = 4'b1111;
               memWdata = sdata_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt_q      <= 8'd0;
         addr_q     <= 32'd0;
         sdata_q    <= 32'd0;
         f3_q       <= 3'd0;
         rd_q       <= 5'd0;
         store_q    <= 1'b0;
         outValid   <= 1'b0;
         wbData     <= 32'd0;
         wbRegdest  <= 5'd0;
         wbWe       <= 1'b0;
         misaligned <= 1'b0;
         busFault   <= 1'b0;
      end else begin
         state      <= state_nx;
         outValid   <= 1'b0;
         misaligned <= 1'b0;
         busFault   <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && !is_mem) begin
                  outValid  <= 1'b1;
                  wbData    <= result;
                  wbRegdest <= regdest;
                  wbWe      <= alu_we;
               end else if (accept && !go_mem) begin
                  outValid   <= 1'b1;
                  misaligned <= 1'b1;
                  wbRegdest  <= regdest;
                  wbWe       <= 1'b0;
               end else if (go_mem) begin
                  addr_q  <= result;
                  sdata_q <= storeData;
                  f3_q    <= funct3;
                  rd_q    <= regdest;
                  store_q <= is_store;
               end
            end
            REQ: begin
               if (memGnt) begin
                  cnt_q <= 8'd0;
                  if (store_q) begin
                     outValid  <= 1'b1;
                     wbRegdest <= rd_q;
                     wbWe      <= 1'b0;
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q + 8'd1;
               // Data arriving on the timeout cycle still completes normally
               if (memRvalid) begin
                  outValid  <= 1'b1;
                  wbData    <= load_ext;
                  wbRegdest <= rd_q;
                  wbWe      <= (rd_q != 5'd0);
               end else if (timeout_hit) begin
                  outValid  <= 1'b1;
                  busFault  <= 1'b1;
                  wbRegdest <= rd_q;
                  wbWe      <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized ops scored
// against a byte-level reference model of the MEM stage rules.
module tb_mem_access_stage;

   localparam int TMO = 4;
   localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, ADD = 7'b0110011;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        inValid = 1'b0, memGnt = 1'b0, memRvalid = 1'b0;
   logic [31:0] result = '0, storeData = '0, memRdata = '0;
   logic [2:0]  funct3 = '0;
   logic [6:0]  opcode = '0;
   logic [4:0]  regdest = '0;
   logic        stall, memReq, memWe, outValid, wbWe, misaligned, busFault;
   logic [31:0] memAddr, memWdata, wbData;
   logic [3:0]  memBe;
   logic [4:0]  wbRegdest;

   int checks = 0, errors = 0;

   mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .inValid(inValid), .result(result), .storeData(storeData),
      .funct3(funct3), .opcode(opcode), .regdest(regdest), .stall(stall), .memReq(memReq),
      .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe), .memGnt(memGnt),
      .memRvalid(memRvalid), .memRdata(memRdata), .outValid(outValid), .wbData(wbData),
      .wbRegdest(wbRegdest), .wbWe(wbWe), .misaligned(misaligned), .busFault(busFault)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // ---------------- reference model ----------------
   // kind: 0 non-memory, 1 fault, 2 load, 3 store
   function automatic int m_kind(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res);
      bit legal;
      int size;
      if (op == LD) legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      else if (op == ST) legal = f3 inside {3'b000, 3'b001, 3'b010};
      else return 0;
      if (!legal) return 1;
      size = 1 << f3[1:0];
      if ((int'(res[1:0]) % size) != 0) return 1;
      return (op == LD) ? 2 : 3;
   endfunction

   function automatic logic [3:0] m_be(input logic [31:0] res, input logic [2:0] f3);
      int off, size;
      logic [3:0] be;
      off = int'(res[1:0]); size = 1 << f3[1:0];
      for (int b = 0; b < 4; b++) be[b] = (b >= off) && (b < off + size);
      return be;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [31:0] sd, input logic [2:0] f3);
      int size;
      logic [31:0] w;
      size = 1 << f3[1:0];
      for (int b = 0; b < 4; b++) w[8*b +: 8] = sd[8*(b % size) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] rdat, input logic [31:0] res, input logic [2:0] f3);
      int off, size;
      longint v;
      off = int'(res[1:0]); size = 1 << f3[1:0]; v = 0;
      for (int i = 0; i < size; i++) v += longint'(rdat[8*(off+i) +: 8]) << (8*i);
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size-1))) v -= longint'(1) << (8*size);
      return v[31:0];
   endfunction

   function automatic bit m_alu_we(input logic [6:0] op, input logic [4:0] rd);
      return (rd != 0) && (op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111});
   endfunction

   // ---------------- driver ----------------
   typedef struct {
      bit timed_out; int lat; int req_cycles; bit req_seen; bit req_unstable; bit req_after_gnt;
      logic [31:0] addr, wdata; logic [3:0] be; logic we;
      int stall_cycles; logic stall_at_out;
      logic [31:0] wb_data; logic [4:0] wb_rd; logic wb_we, mis, bf;
   } obs_t;

   // Presents one op, plays the memory side, and records what the DUT did.
   // rv_dly = WAIT cycle on which rvalid is driven (0 = never).
   task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                         input logic [31:0] sd, input logic [4:0] rd, input int gnt_dly,
                         input int rv_dly, input logic [31:0] rdata, output obs_t o);
      int req_n, wait_n;
      bit granted;
      o = '{default: '0};
      req_n = 0; wait_n = 0; granted = 0;
      inValid = 1'b1; opcode = op; funct3 = f3; result = res; storeData = sd; regdest = rd;
      tick();
      inValid = 1'b0; result = $urandom; storeData = $urandom; regdest = 5'($urandom);
      o.timed_out = 1;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (outValid) begin
            o.timed_out = 0; o.lat = cyc + 1; o.stall_at_out = stall;
            o.wb_data = wbData; o.wb_rd = wbRegdest; o.wb_we = wbWe; o.mis = misaligned; o.bf = busFault;
            break;
         end
         if (stall) o.stall_cycles++;
         memRvalid = 1'b0; memRdata = $urandom;
         if (memReq) begin
            if (granted) o.req_after_gnt = 1;
            if (req_n == 0) begin
               o.req_seen = 1; o.addr = memAddr; o.wdata = memWdata; o.be = memBe; o.we = memWe;
            end else if ({memAddr, memWdata, memBe, memWe} !== {o.addr, o.wdata, o.be, o.we})
               o.req_unstable = 1;
            req_n++;
            memRvalid = 1'($urandom_range(0, 1));
            memGnt = (req_n > gnt_dly);
            if (memGnt) granted = 1;
         end else begin
            memGnt = 1'b0;
            if (granted) begin
               wait_n++;
               if (wait_n == rv_dly) begin memRvalid = 1'b1; memRdata = rdata; end
            end
         end
         tick();
      end
      o.req_cycles = req_n;
      memGnt = 1'b0; memRvalid = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int seen;
      #2;
      checks++; if ({memReq, stall, outValid, wbWe, misaligned, busFault} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b exp 000000", {memReq, stall, outValid, wbWe, misaligned, busFault}); end
      checks++; if ({memAddr, memWdata, memBe, wbData, wbRegdest} !== '0) begin
         errors++; $display("FAIL reset_data: addr %h wdata %h be %b wb %h rd %0d exp all 0", memAddr, memWdata, memBe, wbData, wbRegdest); end
      @(negedge clk); rst_n = 1'b1;
      tick();
      inValid = 1'b1; opcode = LD; funct3 = 3'b010; result = 32'h100; regdest = 5'd7;
      tick();
      inValid = 1'b0;
      checks++; if ({memReq, stall} !== 2'b11) begin
         errors++; $display("FAIL reset_pre_req: memReq/stall %b exp 11", {memReq, stall}); end
      #2; rst_n = 1'b0; #1;
      checks++; if ({memReq, stall, outValid, memBe, memAddr} !== '0) begin
         errors++; $display("FAIL reset_mid_req: req %b stall %b ov %b be %b addr %h exp 0", memReq, stall, outValid, memBe, memAddr); end
      @(negedge clk); rst_n = 1'b1;
      memRvalid = 1'b1; memRdata = 32'hDEADBEEF; seen = 0;
      repeat (3) begin tick(); if (outValid || stall) seen++; end
      memRvalid = 1'b0;
      checks++; if (seen != 0) begin
         errors++; $display("FAIL reset_stale_rvalid: %0d cycles with outValid/stall, exp 0", seen); end
   endtask

   task automatic test_passthrough();
      obs_t o;
      run_op(ADD, 3'b000, 32'h9, 32'h0, 5'd5, 0, 0, 32'h0, o);
      checks++; if (o.timed_out || o.lat != 1) begin errors++; $display("FAIL add_latency: got %0d exp 1", o.lat); end
      checks++; if ({o.wb_data, o.wb_rd, o.wb_we, o.mis, o.bf} !== {32'h9, 5'd5, 3'b100}) begin
         errors++; $display("FAIL add_wb: data %h rd %0d we %b mis %b bf %b exp 9/5/1/0/0", o.wb_data, o.wb_rd, o.wb_we, o.mis, o.bf); end
      checks++; if (o.stall_cycles != 0 || o.stall_at_out !== 1'b0 || o.req_seen) begin
         errors++; $display("FAIL add_stall: stall cycles %0d req %0d exp none", o.stall_cycles, o.req_seen); end
      tick();
      checks++; if (outValid !== 1'b0 || wbData !== 32'h9 || wbRegdest !== 5'd5) begin
         errors++; $display("FAIL add_hold: ov %b wb %h rd %0d exp 0/9/5", outValid, wbData, wbRegdest); end
      run_op(ADD, 3'b000, 32'h9, 32'h0, 5'd0, 0, 0, 32'h0, o);
      checks++; if (o.wb_we !== 1'b0) begin errors++; $display("FAIL add_x0_we: got %b exp 0", o.wb_we); end
      run_op(7'b1100011, 3'b001, 32'h1234, 32'h0, 5'd3, 0, 0, 32'h0, o);
      checks++; if (o.wb_we !== 1'b0 || o.wb_data !== 32'h1234) begin
         errors++; $display("FAIL branch_we: we %b data %h exp 0/00001234", o.wb_we, o.wb_data); end
   endtask

   task automatic test_store();
      obs_t o;
      run_op(ST, 3'b000, 32'h1003, 32'hAB, 5'd1, 2, 0, 32'h0, o);
      checks++; if ({o.addr, o.be, o.wdata, o.we} !== {32'h1000, 4'b1000, 32'hABABABAB, 1'b1}) begin
         errors++; $display("FAIL sb_bus: addr %h be %b wdata %h we %b exp 00001000/1000/abababab/1", o.addr, o.be, o.wdata, o.we); end
      checks++; if (o.req_cycles != 3 || o.req_unstable || o.req_after_gnt) begin
         errors++; $display("FAIL sb_req_hold: cycles %0d unstable %0d after_gnt %0d exp 3/0/0", o.req_cycles, o.req_unstable, o.req_after_gnt); end
      checks++; if (o.timed_out || o.lat != 4 || o.wb_we !== 1'b0 || o.mis !== 1'b0 || o.bf !== 1'b0) begin
         errors++; $display("FAIL sb_done: lat %0d we %b mis %b bf %b exp 4/0/0/0", o.lat, o.wb_we, o.mis, o.bf); end
      run_op(ST, 3'b001, 32'h2002, 32'h1234CDEF, 5'd1, 0, 0, 32'h0, o);
      checks++; if ({o.addr, o.be, o.wdata} !== {32'h2000, 4'b1100, 32'hCDEFCDEF}) begin
         errors++; $display("FAIL sh_bus: addr %h be %b wdata %h exp 00002000/1100/cdefcdef", o.addr, o.be, o.wdata); end
   endtask

   task automatic test_load();
      obs_t o;
      run_op(LD, 3'b000, 32'h2002, 32'h0, 5'd9, 0, 3, 32'h0080FF11, o);
      checks++; if ({o.addr, o.be, o.we} !== {32'h2000, 4'b0100, 1'b0}) begin
         errors++; $display("FAIL lb_bus: addr %h be %b we %b exp 00002000/0100/0", o.addr, o.be, o.we); end
      checks++; if (o.timed_out || o.wb_data !== 32'hFFFFFF80 || o.wb_we !== 1'b1 || o.wb_rd !== 5'd9) begin
         errors++; $display("FAIL lb_data: data %h we %b rd %0d exp ffffff80/1/9", o.wb_data, o.wb_we, o.wb_rd); end
      checks++; if (o.lat != 5 || o.stall_cycles != o.lat - 1 || o.stall_at_out !== 1'b0) begin
         errors++; $display("FAIL lb_stall: lat %0d stall cycles %0d stall@out %b exp 5/4/0", o.lat, o.stall_cycles, o.stall_at_out); end
      run_op(LD, 3'b100, 32'h2002, 32'h0, 5'd9, 1, 3, 32'h0080FF11, o);
      checks++; if (o.wb_data !== 32'h00000080 || o.bf !== 1'b0) begin
         errors++; $display("FAIL lbu_data: data %h bf %b exp 00000080/0", o.wb_data, o.bf); end
      run_op(LD, 3'b001, 32'h2002, 32'h0, 5'd0, 0, 1, 32'h8001FF11, o);
      checks++; if (o.wb_data !== 32'hFFFF8001 || o.wb_we !== 1'b0) begin
         errors++; $display("FAIL lh_x0: data %h we %b exp ffff8001/0", o.wb_data, o.wb_we); end
   endtask

   task automatic test_misaligned();
      obs_t o;
      run_op(LD, 3'b010, 32'h6, 32'h0, 5'd4, 0, 1, 32'h0, o);
      checks++; if (o.timed_out || o.lat != 1 || o.req_seen || o.mis !== 1'b1 || o.wb_we !== 1'b0 || o.bf !== 1'b0) begin
         errors++; $display("FAIL lw_misaligned: lat %0d req %0d mis %b we %b bf %b exp 1/0/1/0/0", o.lat, o.req_seen, o.mis, o.wb_we, o.bf); end
      run_op(ST, 3'b001, 32'h5, 32'h0, 5'd4, 0, 0, 32'h0, o);
      checks++; if (o.lat != 1 || o.req_seen || o.mis !== 1'b1 || o.wb_we !== 1'b0) begin
         errors++; $display("FAIL sh_misaligned: lat %0d req %0d mis %b we %b exp 1/0/1/0", o.lat, o.req_seen, o.mis, o.wb_we); end
      run_op(LD, 3'b011, 32'h8, 32'h0, 5'd4, 0, 1, 32'h0, o);
      checks++; if (o.req_seen || o.mis !== 1'b1) begin
         errors++; $display("FAIL illegal_f3: req %0d mis %b exp 0/1", o.req_seen, o.mis); end
      tick();
      checks++; if (misaligned !== 1'b0 || outValid !== 1'b0) begin
         errors++; $display("FAIL mis_pulse: mis %b ov %b exp 0/0", misaligned, outValid); end
   endtask

   task automatic test_timeout();
      obs_t o;
      run_op(LD, 3'b010, 32'h40, 32'h0, 5'd6, 1, 0, 32'h0, o);
      checks++; if (o.timed_out || o.lat != 1 + 2 + TMO || o.bf !== 1'b1 || o.wb_we !== 1'b0 || o.mis !== 1'b0) begin
         errors++; $display("FAIL timeout_fault: lat %0d bf %b we %b mis %b exp %0d/1/0/0", o.lat, o.bf, o.wb_we, o.mis, 3 + TMO); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL timeout_idle: stall %b exp 0", stall); end
      run_op(LD, 3'b010, 32'h40, 32'h0, 5'd6, 0, TMO, 32'h13579BDF, o);
      checks++; if (o.bf !== 1'b0 || o.wb_data !== 32'h13579BDF || o.wb_we !== 1'b1 || o.lat != 2 + TMO) begin
         errors++; $display("FAIL timeout_data_wins: bf %b data %h we %b lat %0d exp 0/13579bdf/1/%0d", o.bf, o.wb_data, o.wb_we, o.lat, 2 + TMO); end
   endtask

   task automatic test_back_to_back();
      obs_t o;
      run_op(ADD, 3'b000, 32'h11, 32'h0, 5'd2, 0, 0, 32'h0, o);
      run_op(7'b0010011, 3'b000, 32'h22, 32'h0, 5'd3, 0, 0, 32'h0, o);
      checks++; if (o.lat != 1 || o.wb_data !== 32'h22 || o.wb_rd !== 5'd3 || o.wb_we !== 1'b1) begin
         errors++; $display("FAIL b2b_alu: lat %0d data %h rd %0d we %b exp 1/22/3/1", o.lat, o.wb_data, o.wb_rd, o.wb_we); end
      run_op(LD, 3'b101, 32'h3002, 32'h0, 5'd8, 0, 2, 32'hBEEF0000, o);
      checks++; if (o.wb_data !== 32'h0000BEEF || o.lat != 4) begin
         errors++; $display("FAIL b2b_lhu: data %h lat %0d exp 0000beef/4", o.wb_data, o.lat); end
   endtask

   task automatic test_random();
      obs_t o;
      logic [6:0] ops[9];
      logic [6:0] op;
      logic [2:0] f3;
      logic [31:0] res, sd, rdat;
      logic [4:0] rd;
      int gd, rv, kind, w, exp_lat;
      ops = '{LD, LD, LD, ST, ST, 7'b0110011, 7'b0110111, 7'b1100011, 7'b1101111};
      for (int n = 0; n < 60; n++) begin
         op = (n % 10 == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
         f3 = 3'($urandom); res = $urandom; sd = $urandom; rdat = $urandom;
         rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         gd = $urandom_range(0, 3); rv = $urandom_range(1, TMO + 2);
         kind = m_kind(op, f3, res);
         run_op(op, f3, res, sd, rd, gd, rv, rdat, o);
         w = (rv <= TMO) ? rv : TMO;
         exp_lat = (kind == 2) ? gd + 2 + w : (kind == 3) ? gd + 2 : 1;
         checks++; if (o.timed_out || o.lat != exp_lat || o.mis !== (kind == 1) || o.req_seen != (kind >= 2)) begin
            errors++; $display("FAIL rnd_flow[%0d]: op %b f3 %b addr %h lat %0d/%0d mis %b req %0d kind %0d", n, op, f3, res, o.lat, exp_lat, o.mis, o.req_seen, kind); end
         if (kind == 0) begin
            checks++; if (o.wb_data !== res || o.wb_rd !== rd || o.wb_we !== m_alu_we(op, rd) || o.bf !== 1'b0) begin
               errors++; $display("FAIL rnd_alu[%0d]: data %h/%h rd %0d/%0d we %b", n, o.wb_data, res, o.wb_rd, rd, o.wb_we); end
         end else if (kind == 1) begin
            checks++; if (o.wb_we !== 1'b0 || o.bf !== 1'b0) begin
               errors++; $display("FAIL rnd_fault[%0d]: we %b bf %b exp 0/0", n, o.wb_we, o.bf); end
         end else begin
            checks++; if (o.addr !== {res[31:2], 2'b00} || o.be !== m_be(res, f3) || o.we !== (kind == 3) ||
                          (kind == 3 && o.wdata !== m_wdata(sd, f3)) || o.req_unstable || o.req_cycles != gd + 1) begin
               errors++; $display("FAIL rnd_bus[%0d]: addr %h be %b/%b we %b wdata %h/%h unstable %0d cycles %0d", n, o.addr, o.be, m_be(res, f3), o.we, o.wdata, m_wdata(sd, f3), o.req_unstable, o.req_cycles); end
            if (kind == 3) begin
               checks++; if (o.wb_we !== 1'b0 || o.bf !== 1'b0) begin
                  errors++; $display("FAIL rnd_store_wb[%0d]: we %b bf %b exp 0/0", n, o.wb_we, o.bf); end
            end else if (rv <= TMO) begin
               checks++; if (o.bf !== 1'b0 || o.wb_data !== m_load(rdat, res, f3) || o.wb_we !== (rd != 0) || o.wb_rd !== rd) begin
                  errors++; $display("FAIL rnd_load[%0d]: f3 %b data %h exp %h we %b rd %0d bf %b", n, f3, o.wb_data, m_load(rdat, res, f3), o.wb_we, o.wb_rd, o.bf); end
            end else begin
               checks++; if (o.bf !== 1'b1 || o.wb_we !== 1'b0) begin
                  errors++; $display("FAIL rnd_timeout[%0d]: bf %b we %b exp 1/0", n, o.bf, o.wb_we); end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_store();
      test_load();
      test_misaligned();
      test_timeout();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
